// File: rtl/program_loader.sv
// program_loader: packs a little-endian byte stream into 32-bit words and writes
// them to instruction memory from word 0 upward, holding the CPU in reset until done.
// Latency: mem_we asserts the cycle after the 4th byte of a word; peak 4 bytes / 5 cycles.
// Backpressure: in_ready is a pure state decode (RECV/CHECK only); bytes are never
// consumed while in_ready is low, including the single WRITE cycle per word.
//
// Optional build macro: LOADER_CHECKSUM_EN adds a CHECK state that consumes one
// trailing checksum byte; the load passes when the 8-bit sum of all bytes is zero.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   start, word_count  load request and number of words (1..MEM_WORDS)
//   in_valid, in_data, in_ready   byte stream handshake
//   mem_we, mem_addr, mem_wdata   instruction-memory write port
//   cpu_reset, busy, done, error  status towards the CPU / host
module program_loader #(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
`ifdef LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   word_cnt;
  logic [CNT_W-1:0]   word_inc;
  logic [1:0]         idx;
  logic [31:0]        asm_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic               error_q;
  logic               count_ok;
  logic               start_ok_state;
  logic               start_acc;
  logic               start_rej;
  logic               ck_fail;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         sum_q;
`endif

  assign count_ok       = (word_count != '0) && (word_count <= CNT_W'(MEM_WORDS));
  assign start_ok_state = (state == IDLE) || (state == DONE);
  assign start_acc      = start && count_ok && start_ok_state;
  assign start_rej      = start && !count_ok && start_ok_state;
  assign word_inc       = word_cnt + 1'b1;

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign error     = error_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cpu_reset = 1'b1;
    ck_fail   = 1'b0;
    case (state)
      IDLE: begin
        if (start_acc) state_nxt = RECV;
      end
      RECV: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && (idx == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (word_inc == count_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = RECV;
        end
      end
      DONE: begin
        // A re-load puts the CPU back into reset in the very cycle it is accepted.
        done      = !start_acc;
        cpu_reset = start_acc;
        if (start_acc) state_nxt = RECV;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          if (8'(sum_q + in_data) == 8'd0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = IDLE;
            ck_fail   = 1'b1;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // Reset wins immediately: no write strobe and the CPU stays held.
    if (reset) begin
      mem_we    = 1'b0;
      done      = 1'b0;
      cpu_reset = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      word_cnt    <= '0;
      idx         <= '0;
      asm_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      if (start_rej) error_q <= 1'b1;
      if (start_acc) begin
        count_q  <= word_count;
        word_cnt <= '0;
        idx      <= '0;
        error_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_q    <= '0;
`endif
      end
      if ((state == RECV) && in_valid) begin
        asm_q[{idx, 3'b000} +: 8] <= in_data;
        idx <= idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        sum_q <= sum_q + in_data;
`endif
        // Write port registers are loaded only here so they hold outside WRITE.
        if (idx == 2'd3) begin
          mem_addr_q  <= word_cnt[ADDR_W-1:0];
          mem_wdata_q <= {in_data, asm_q[23:0]};
        end
      end
      if (state == WRITE) begin
        word_cnt <= word_inc;
        idx      <= '0;
      end
      if (ck_fail) error_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int MW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  program_loader #(.MEM_WORDS(MW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rdy_in_write = 0;
  int          comp_bad = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  tb_sum;
  logic [7:0]  pat [8];

  // Write log plus two invariants: in_ready low while writing, done == !cpu_reset.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we === 1'b1) begin
        wr_addr_q.push_back(32'(mem_addr));
        wr_data_q.push_back(mem_wdata);
        if (in_ready !== 1'b0) rdy_in_write++;
      end
      if (done === cpu_reset) comp_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the edge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    tb_sum   = tb_sum + b;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic start_load(input logic [AW:0] cnt);
    word_count = cnt;
    start      = 1'b1;
    tick();
    start  = 1'b0;
    tb_sum = 8'h00;
  endtask

  // Trailing checksum byte when the checksum build is active.
  task automatic finish_ck();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] ck;
    ck = 8'h00 - tb_sum;
    send_byte(ck);
`endif
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  initial begin
    pat[0] = 8'h13; pat[1] = 8'h00; pat[2] = 8'h10; pat[3] = 8'h00;
    pat[4] = 8'h93; pat[5] = 8'h00; pat[6] = 8'h20; pat[7] = 8'h00;
    reset = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
    tb_sum = 8'h00;
    tick();
    tick();
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Basic two-word load.
    start_load(2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    chk("t1_cpu_reset", 32'(cpu_reset), 32'd1);
    send_word(32'h00100013);
    chk("t1_we0", 32'(mem_we), 32'd1);
    chk("t1_addr0", 32'(mem_addr), 32'd0);
    chk("t1_data0", mem_wdata, 32'h00100013);
    chk("t1_rdy_in_write", 32'(in_ready), 32'd0);
    tick();
    chk("t1_we_off", 32'(mem_we), 32'd0);
    chk("t1_back_recv", 32'(in_ready), 32'd1);
    send_word(32'h00200093);
    chk("t1_we1", 32'(mem_we), 32'd1);
    chk("t1_addr1", 32'(mem_addr), 32'd1);
    chk("t1_data1", mem_wdata, 32'h00200093);
    chk("t1_hold_reset", 32'(cpu_reset), 32'd1);
    tick();
    finish_ck();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cpu_run", 32'(cpu_reset), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_addr_hold", 32'(mem_addr), 32'd1);
    chk("t1_data_hold", mem_wdata, 32'h00200093);
    chk("t1_nwr", 32'(wr_data_q.size()), 32'd2);
    chk("t1_log_a0", wr_addr_q[0], 32'd0);
    chk("t1_log_d0", wr_data_q[0], 32'h00100013);
    chk("t1_log_a1", wr_addr_q[1], 32'd1);
    chk("t1_log_d1", wr_data_q[1], 32'h00200093);

    // Re-load from DONE with in_valid toggling every cycle.
    clear_log();
    word_count = 2;
    start = 1'b1;
    #1;
    chk("t2_start_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t2_start_done", 32'(done), 32'd0);
    tick();
    start  = 1'b0;
    tb_sum = 8'h00;
    begin
      int p;
      p = 0;
      for (int c = 0; c < 200 && p < 8; c++) begin
        in_valid = c[0];
        in_data  = pat[p];
        if (in_valid && in_ready) begin
          tb_sum = tb_sum + pat[p];
          p++;
        end
        tick();
      end
      in_valid = 1'b0;
    end
    tick();
    finish_ck();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_nwr", 32'(wr_data_q.size()), 32'd2);
    chk("t2_log_a0", wr_addr_q[0], 32'd0);
    chk("t2_log_d0", wr_data_q[0], 32'h00100013);
    chk("t2_log_a1", wr_addr_q[1], 32'd1);
    chk("t2_log_d1", wr_data_q[1], 32'h00200093);

    // Rejected starts from IDLE.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_log();
    start_load(0);
    chk("t3_err0", 32'(error), 32'd1);
    chk("t3_busy0", 32'(busy), 32'd0);
    chk("t3_rdy0", 32'(in_ready), 32'd0);
    chk("t3_cpu0", 32'(cpu_reset), 32'd1);
    start_load(33);
    chk("t3_err33", 32'(error), 32'd1);
    chk("t3_busy33", 32'(busy), 32'd0);
    chk("t3_rdy33", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("t3_nwr", 32'(wr_data_q.size()), 32'd0);
    start_load(1);
    chk("t3_err_clr", 32'(error), 32'd0);
    chk("t3_busy1", 32'(busy), 32'd1);
    send_word(32'hDEADBEEF);
    chk("t3_we", 32'(mem_we), 32'd1);
    chk("t3_addr", 32'(mem_addr), 32'd0);
    chk("t3_data", mem_wdata, 32'hDEADBEEF);
    tick();
    finish_ck();
    chk("t3_done", 32'(done), 32'd1);

    // Reset in the middle of the second word.
    clear_log();
    start_load(2);
    send_word(32'h00100013);
    tick();
    send_byte(8'h93);
    send_byte(8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_cpu", 32'(cpu_reset), 32'd1);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_rdy", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("t4_nwr", 32'(wr_data_q.size()), 32'd1);
    // Reset arriving during the WRITE cycle must suppress the strobe.
    start_load(1);
    send_word(32'hCAFEF00D);
    reset = 1'b1;
    #1;
    chk("t4_we_in_reset", 32'(mem_we), 32'd0);
    tick();
    reset = 1'b0;
    chk("t4_we_after_reset", 32'(mem_we), 32'd0);
    chk("t4_nwr2", 32'(wr_data_q.size()), 32'd1);
    start_load(1);
    send_word(32'h44332211);
    chk("t4_addr", 32'(mem_addr), 32'd0);
    chk("t4_data", mem_wdata, 32'h44332211);
    tick();
    finish_ck();
    chk("t4_done2", 32'(done), 32'd1);

    // start pulsed in RECV must not disturb the load.
    clear_log();
    start_load(2);
    send_byte(8'h01);
    send_byte(8'h02);
    word_count = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h03);
    send_byte(8'h04);
    chk("t5_addr0", 32'(mem_addr), 32'd0);
    chk("t5_data0", mem_wdata, 32'h04030201);
    tick();
    chk("t5_not_done", 32'(done), 32'd0);
    chk("t5_still_recv", 32'(in_ready), 32'd1);
    send_word(32'h08070605);
    chk("t5_addr1", 32'(mem_addr), 32'd1);
    chk("t5_data1", mem_wdata, 32'h08070605);
    tick();
    finish_ck();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_nwr", 32'(wr_data_q.size()), 32'd2);

`ifdef LOADER_CHECKSUM_EN
    start_load(1);
    send_word(32'h04030201);
    tick();
    chk("t6_check_rdy", 32'(in_ready), 32'd1);
    chk("t6_check_busy", 32'(busy), 32'd1);
    send_byte(8'hF6);
    chk("t6_pass_done", 32'(done), 32'd1);
    chk("t6_pass_err", 32'(error), 32'd0);
    chk("t6_pass_cpu", 32'(cpu_reset), 32'd0);
    start_load(1);
    send_word(32'h04030201);
    tick();
    send_byte(8'h00);
    chk("t6_fail_err", 32'(error), 32'd1);
    chk("t6_fail_done", 32'(done), 32'd0);
    chk("t6_fail_cpu", 32'(cpu_reset), 32'd1);
    chk("t6_fail_busy", 32'(busy), 32'd0);
`endif

    chk("inv_rdy_in_write", 32'(rdy_in_write), 32'd0);
    chk("inv_done_vs_cpu_reset", 32'(comp_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface: receives a little-endian byte stream over a valid/ready handshake, packs it into 32-bit words and writes them to consecutive instruction-memory word addresses starting at 0.
- Holds the CPU in reset (cpu_reset) until a complete program has been written, then releases it so fetch starts at PC 0.
- Sits between the host/UART byte source and the instruction-memory write port.

Parameters:
- MEM_WORDS, 32, depth of instruction memory in 32-bit words.
- ADDR_W, 5, word-address width; must satisfy 2**ADDR_W >= MEM_WORDS.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a load
- word_count  input  ADDR_W+1  number of words to load; sampled only on an accepted start
- in_valid  input  1  in_data holds a valid byte
- in_data  input  8  stream byte; the first byte of each word is bits [7:0]
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  ADDR_W  word address of the write
- mem_wdata  output  32  word written
- cpu_reset  output  1  high while the CPU must stay in reset
- busy  output  1  load in progress
- done  output  1  program loaded; sticky until the next accepted start
- error  output  1  last start was rejected or the last load failed; sticky until the next accepted start

Behaviour:
- Reset values: state IDLE; in_ready, mem_we, busy, done and error 0; cpu_reset 1; mem_addr 0; mem_wdata 0; byte index 0; word counter 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - cpu_reset=1, in_ready=0.
  - An accepted start requires 1 <= word_count <= MEM_WORDS. It latches the count, clears done, error and the word counter, and moves to RECV on the next cycle.
  - A start with word_count 0 or greater than MEM_WORDS sets error=1 and stays in IDLE.
- RECV:
  - busy=1, in_ready=1. A byte transfers when in_valid && in_ready.
  - The byte goes into lane [8*idx+7 : 8*idx] of the assembly register, then idx increments.
  - On the 4th byte (idx==3), go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=word counter, mem_wdata=assembled word, in_ready=0.
  - The word counter then increments.
  - If the new counter equals the latched count, go to DONE; otherwise return to RECV with idx=0.
- Latency and throughput: mem_we asserts the cycle after the 4th byte's handshake. Peak rate is 4 bytes per 5 cycles.
- DONE:
  - done=1, busy=0, cpu_reset=0, in_ready=0.
  - An accepted start re-enters the load. cpu_reset rises in the same cycle the start is accepted, and done clears.
- Ignored inputs:
  - start is ignored in RECV and WRITE.
  - in_valid is ignored whenever in_ready=0; no byte is consumed.
- Timing: the word counter never exceeds the latched count, so mem_addr never wraps. in_ready is a registered state decode and has no combinational path from in_valid.
- reset in any state:
  - Return to IDLE on the next edge and discard the partial word.
  - No mem_we pulse in the reset cycle or after it.
  - cpu_reset=1, done=0.
- mem_addr and mem_wdata hold their last values outside WRITE.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the final WRITE, enter state CHECK with in_ready=1 and accept one checksum byte.
  - A load passes when the 8-bit sum of all data bytes plus the checksum byte, modulo 256, equals 0.
  - Pass: go to DONE.
  - Fail: error=1 and return to IDLE; cpu_reset stays 1 and done stays 0. Memory already written is not rolled back.
- Undefined: no CHECK state and no checksum byte. error is set only by a rejected start.

Test Plan:
- reset, then start with word_count=2; bytes 13,00,10,00,93,00,20,00 -> mem_we at addr 0 data 0x00100013, then addr 1 data 0x00200093; done=1, cpu_reset falls the same cycle done rises.
- Same load with in_valid toggled 1/0 every cycle -> identical writes; no byte is lost or duplicated; in_ready=0 during each WRITE cycle.
- start with word_count=0, then with word_count=33 (MEM_WORDS=32) -> error=1, state stays IDLE, no mem_we, cpu_reset=1; a following start with word_count=1 clears error.
- reset asserted after 2 bytes of the 2nd word -> no further mem_we, busy=0, cpu_reset=1; a new start with word_count=1 and 4 bytes writes addr 0 correctly.
- start pulsed while in RECV -> ignored; the latched count is unchanged and the load completes with the original count.
- With LOADER_CHECKSUM_EN, word_count=1, bytes 01,02,03,04 plus checksum 0xF6 -> done=1; the same bytes with checksum 0x00 -> error=1, done=0, cpu_reset=1.
